load_store_unit: RTL and testbench

//  Memory-access stage of the multicycle RV64 datapath: sits between the ALU (effective address) and the

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 194 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the request/response handshake between the control FSM and the
//   load/store unit, together with the doubleword data-memory port.
//
//   Request   : req_valid, req_ready, req_store, req_funct3, req_addr, req_wdata
//   Response  : resp_valid, resp_rdata, resp_error
//   Memory    : mem_addr, mem_wr, mem_wdata, mem_rdata
//
//   Modports
//     slave  - the load/store unit itself
//     master - the environment (control FSM plus data memory)
// ----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;

  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Memory-access stage of the multicycle RV64 datapath. Executes
//   LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD against a doubleword-wide memory.
//   Sub-word stores are done by read-modify-write; misaligned addresses and
//   illegal funct3 codes complete immediately with resp_error set.
//
//   Parameters
//     MEM_LAT : cycles from mem_addr presented to mem_rdata valid (>= 1)
//
//   Ports
//     clk    : clock, rising edge
//     reset  : asynchronous, active-high reset
//     bus    : load_store_unit_if.slave (request, response and memory signals)
// ----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int unsigned    CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0]  LAT_LAST = CW'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;

  logic          r_store;
  logic [2:0]    r_f3;
  logic [2:0]    r_off;
  logic [63:0]   r_wdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_resp_rdata;
  logic [63:0]   r_mem_addr;
  logic [63:0]   r_mem_wdata;

  logic          w_accept;
  logic          w_req_err;
  logic          w_lat_done;
  logic [7:0]    w_byte_mask;
  logic [63:0]   w_bit_mask;
  logic [63:0]   w_shift_wdata;
  logic [63:0]   w_merged;
  logic [63:0]   w_field;
  logic [63:0]   w_extracted;

  // Request legality: funct3=111 is undefined, stores have no unsigned forms,
  // and every access must be naturally aligned to its size.
  always_comb begin
    w_req_err = 1'b0;
    if (bus.req_funct3 == 3'b111)
      w_req_err = 1'b1;
    else if (bus.req_store && bus.req_funct3[2])
      w_req_err = 1'b1;
    else begin
      case (bus.req_funct3[1:0])
        2'b01:   w_req_err = bus.req_addr[0];
        2'b10:   w_req_err = |bus.req_addr[1:0];
        2'b11:   w_req_err = |bus.req_addr[2:0];
        default: w_req_err = 1'b0;
      endcase
    end
  end

  assign w_accept   = (r_state == IDLE) && bus.req_valid;
  assign w_lat_done = (r_cnt == LAT_LAST);

  // Store merge: replace bytes [off +: size] of the read doubleword with the
  // low bytes of the store data.
  always_comb begin
    w_byte_mask = '0;
    w_bit_mask  = '0;
    case (r_f3[1:0])
      2'b00:   w_byte_mask = 8'h01 << r_off;
      2'b01:   w_byte_mask = 8'h03 << r_off;
      2'b10:   w_byte_mask = 8'h0F << r_off;
      default: w_byte_mask = 8'hFF;
    endcase
    for (int unsigned i = 0; i < 8; i++)
      w_bit_mask[8*i +: 8] = {8{w_byte_mask[i]}};
    w_shift_wdata = r_wdata << {r_off, 3'b000};
    w_merged      = (bus.mem_rdata & ~w_bit_mask) | (w_shift_wdata & w_bit_mask);
  end

  // Load extract: right-align the addressed field, then sign/zero extend.
  always_comb begin
    w_field     = bus.mem_rdata >> {r_off, 3'b000};
    w_extracted = '0;
    case (r_f3)
      3'b000:  w_extracted = {{56{w_field[7]}},  w_field[7:0]};
      3'b001:  w_extracted = {{48{w_field[15]}}, w_field[15:0]};
      3'b010:  w_extracted = {{32{w_field[31]}}, w_field[31:0]};
      3'b011:  w_extracted = w_field;
      3'b100:  w_extracted = {56'b0, w_field[7:0]};
      3'b101:  w_extracted = {48'b0, w_field[15:0]};
      3'b110:  w_extracted = {32'b0, w_field[31:0]};
      default: w_extracted = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_error = 1'b0;
    bus.mem_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = ~reset;
        if (bus.req_valid) begin
          if (w_req_err)
            w_next = RESP;
          else if (bus.req_store && (bus.req_funct3[1:0] == 2'b11))
            w_next = WRITE;
          else
            w_next = READ;
        end
      end
      READ: begin
        if (w_lat_done)
          w_next = r_store ? WRITE : RESP;
      end
      WRITE: begin
        bus.mem_wr = 1'b1;
        w_next     = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_error = r_err;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store      <= 1'b0;
      r_f3         <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      if (w_accept) begin
        r_store <= bus.req_store;
        r_f3    <= bus.req_funct3;
        r_off   <= bus.req_addr[2:0];
        r_wdata <= bus.req_wdata;
        r_err   <= w_req_err;
        r_cnt   <= '0;
        // Stores and errors always answer zero; loads keep the previous value
        // until the new one is captured at the end of READ.
        if (w_req_err || bus.req_store)
          r_resp_rdata <= '0;
        if (!w_req_err) begin
          r_mem_addr <= {bus.req_addr[63:3], 3'b000};
          if (bus.req_store && (bus.req_funct3[1:0] == 2'b11))
            r_mem_wdata <= bus.req_wdata;
        end
      end
      if (r_state == READ) begin
        if (w_lat_done) begin
          if (r_store)
            r_mem_wdata <= w_merged;
          else
            r_resp_rdata <= w_extracted;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit with a 16-doubleword behavioural
//   memory (combinational read, i.e. MEM_LAT=1). Expected responses are
//   queued when a request is driven and compared when resp_valid appears.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem [16];
  assign bus.mem_rdata = mem[bus.mem_addr[6:3]];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[6:3]] <= bus.mem_wdata;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          lat;
    int          wr;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int passes = 0;
  int wr_count = 0;
  int rv_count = 0;
  int acc_count = 0;
  logic [63:0] last_wdata = '0;

  always @(negedge clk) begin
    if (bus.mem_wr) begin
      wr_count++;
      last_wdata = bus.mem_wdata;
    end
    if (bus.resp_valid) rv_count++;
    if (bus.req_ready && bus.req_valid) acc_count++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    @(posedge clk); #1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
  endtask

  // Returns at accept edge + #1.
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk({tag, "_accept_timeout"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input string tag, output int acc_at_resp);
    exp_t e;
    int   lat;
    int   wr0;
    wr0 = wr_count;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 30);
    #1;
    acc_at_resp = acc_count;
    if (!bus.resp_valid) begin
      chk({tag, "_resp_timeout"}, 64'(bus.resp_valid), 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, bus.resp_rdata, e.rd);
      chk({tag, "_error"}, 64'(bus.resp_error), 64'(e.err));
      chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
      chk({tag, "_mem_wr_count"}, 64'(wr_count - wr0), 64'(e.wr));
    end
    @(negedge clk); #1;
    chk({tag, "_resp_one_cycle"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_wr);
    int dummy;
    drive(st, f3, a, wd);
    sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat, wr: exp_wr});
    wait_accept(tag);
    bus.req_valid = 1'b0;
    wait_resp(tag, dummy);
  endtask

  initial begin
    int wr0;
    int rv0;
    int acc0;
    int acc_r;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 16; i++) mem[i] <= '0;
    mem[2] <= 64'h8877665544332211;
    mem[4] <= 64'hDEADBEEFCAFEBABE;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_error", 64'(bus.resp_error), 64'd0);
    chk("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // Loads from the doubleword at 0x10
    issue("ld_10",  1'b0, 3'b011, 64'h10, '0, 64'h8877665544332211, 1'b0, 2, 0);
    chk("ld_10_mem_addr", bus.mem_addr, 64'h10);
    issue("lb_17",  1'b0, 3'b000, 64'h17, '0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 0);
    issue("lbu_17", 1'b0, 3'b100, 64'h17, '0, 64'h0000000000000088, 1'b0, 2, 0);
    issue("lhu_16", 1'b0, 3'b101, 64'h16, '0, 64'h0000000000008877, 1'b0, 2, 0);
    issue("lh_16",  1'b0, 3'b001, 64'h16, '0, 64'hFFFFFFFFFFFF8877, 1'b0, 2, 0);
    issue("lwu_14", 1'b0, 3'b110, 64'h14, '0, 64'h0000000088776655, 1'b0, 2, 0);
    issue("lw_14",  1'b0, 3'b010, 64'h14, '0, 64'hFFFFFFFF88776655, 1'b0, 2, 0);
    issue("lb_10",  1'b0, 3'b000, 64'h10, '0, 64'h0000000000000011, 1'b0, 2, 0);

    // Stores
    issue("sb_13", 1'b1, 3'b000, 64'h13, 64'h123456789ABCDEAB, '0, 1'b0, 3, 1);
    chk("sb_13_wdata", last_wdata, 64'h88776655AB332211);
    issue("lw_10", 1'b0, 3'b010, 64'h10, '0, 64'hFFFFFFFFAB332211, 1'b0, 2, 0);
    issue("sd_08", 1'b1, 3'b011, 64'h08, 64'h0123456789ABCDEF, '0, 1'b0, 2, 1);
    chk("sd_08_wdata", last_wdata, 64'h0123456789ABCDEF);
    issue("sh_0a", 1'b1, 3'b001, 64'h0A, 64'hFFFFFFFFFFFFBEEF, '0, 1'b0, 3, 1);
    chk("sh_0a_wdata", last_wdata, 64'h01234567BEEFCDEF);
    issue("sw_0c", 1'b1, 3'b010, 64'h0C, 64'h00000000CAFEF00D, '0, 1'b0, 3, 1);
    chk("sw_0c_wdata", last_wdata, 64'hCAFEF00DBEEFCDEF);
    issue("ld_08", 1'b0, 3'b011, 64'h08, '0, 64'hCAFEF00DBEEFCDEF, 1'b0, 2, 0);

    // Errors: misaligned or illegal funct3
    issue("err_lw_12",  1'b0, 3'b010, 64'h12, '0, '0, 1'b1, 1, 0);
    issue("err_sd_0c",  1'b1, 3'b011, 64'h0C, 64'h1111111111111111, '0, 1'b1, 1, 0);
    issue("err_f3_111", 1'b0, 3'b111, 64'h10, '0, '0, 1'b1, 1, 0);
    issue("ld_10_b",    1'b0, 3'b011, 64'h10, '0, 64'h88776655AB332211, 1'b0, 2, 0);
    issue("err_lh_11",  1'b0, 3'b001, 64'h11, '0, '0, 1'b1, 1, 0);
    issue("err_sbu",    1'b1, 3'b100, 64'h10, 64'h22, '0, 1'b1, 1, 0);
    issue("ld_10_c",    1'b0, 3'b011, 64'h10, '0, 64'h88776655AB332211, 1'b0, 2, 0);

    // Reset during the READ phase of a sub-word store
    drive(1'b1, 3'b001, 64'h20, 64'h0000000000001234);
    wait_accept("rst_sh_20");
    bus.req_valid = 1'b0;
    wr0 = wr_count;
    rv0 = rv_count;
    reset = 1'b1;
    #1;
    chk("rst_mid_ready_low", 64'(bus.req_ready), 64'd0);
    chk("rst_mid_mem_wr", 64'(bus.mem_wr), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_no_wr", 64'(wr_count - wr0), 64'd0);
    chk("rst_mid_no_resp", 64'(rv_count - rv0), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready), 64'd1);
    issue("ld_20", 1'b0, 3'b011, 64'h20, '0, 64'hDEADBEEFCAFEBABE, 1'b0, 2, 0);

    // req_valid held high: one accept per transaction
    acc0 = acc_count;
    drive(1'b0, 3'b011, 64'h08, '0);
    sb.push_back('{rd: 64'hCAFEF00DBEEFCDEF, err: 1'b0, lat: 2, wr: 0});
    sb.push_back('{rd: 64'hCAFEF00DBEEFCDEF, err: 1'b0, lat: 2, wr: 0});
    wait_accept("hold1");
    wait_resp("hold1", acc_r);
    chk("hold_accepts_at_resp", 64'(acc_r - acc0), 64'd1);
    chk("hold_second_accept", 64'(acc_count - acc0), 64'd2);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp("hold2", acc_r);
    chk("hold_total_accepts", 64'(acc_count - acc0), 64'd2);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
